nand_target_emu: RTL

NAND_TARGET_EMU -- requirements
Module: nand_target_emu

---
 rtl/nand_target_pkg.sv | 48 ++++
 rtl/nand_pin_sync.sv | 59 +++++
 rtl/nand_target_emu.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nand_target_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nand_target_pkg                                            |
// | Purpose  : Opcodes, FSM states and helpers for the NAND target        |
// |            emulator.                                                  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package nand_target_pkg;

    localparam logic [7:0] c_CMD_READ      = 8'h00;
    localparam logic [7:0] c_CMD_READ_CONF = 8'h30;
    localparam logic [7:0] c_CMD_ERASE     = 8'h60;
    localparam logic [7:0] c_CMD_STATUS    = 8'h70;
    localparam logic [7:0] c_CMD_PROG      = 8'h80;
    localparam logic [7:0] c_CMD_READ_ID   = 8'h90;
    localparam logic [7:0] c_CMD_PROG_CONF = 8'h10;
    localparam logic [7:0] c_CMD_ERASE_CNF = 8'hD0;
    localparam logic [7:0] c_CMD_RESET     = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR       = 3'd1,
        ST_PROG_DATA  = 3'd2,
        ST_BUSY       = 3'd3,
        ST_OUT_ID     = 3'd4,
        ST_OUT_STATUS = 3'd5,
        ST_OUT_PAGE   = 3'd6
    } nand_state_e;

    // What the busy timer is doing, so its expiry knows what to commit.
    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_PROG  = 2'd1,
        OP_ERASE = 2'd2,
        OP_RESET = 2'd3
    } busy_op_e;

    // Number of address cycles that follow an address-taking opcode.
    function automatic logic [2:0] addr_cycles(input logic [7:0] cmd);
        case (cmd)
            c_CMD_READ_ID: return 3'd1;
            c_CMD_ERASE:   return 3'd3;
            default:       return 3'd5;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_pin_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nand_pin_sync                                              |
// | Purpose  : Two-flop synchronizer for the NAND pins plus rising-edge   |
// |            detection on nWE, nRE and nCE.                             |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module nand_pin_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_nwe,
    input  logic       i_nre,
    input  logic       i_cle,
    input  logic       i_ale,
    input  logic       i_nce,
    input  logic       i_nwp,
    input  logic [7:0] i_data,
    output logic       o_cle,
    output logic       o_ale,
    output logic       o_nce,
    output logic       o_nwp,
    output logic [7:0] o_data,
    output logic       o_nwe_rise,
    output logic       o_nre_rise,
    output logic       o_nce_rise
);

    // Bit map: 0 nwe, 1 nre, 2 cle, 3 ale, 4 nce, 5 nwp, 13:6 data
    logic [13:0] w_raw;
    logic [13:0] r_meta;
    logic [13:0] r_sync;
    logic [2:0]  r_prev;   // previous synced {nce, nre, nwe}

    assign w_raw = {i_data, i_nwp, i_nce, i_ale, i_cle, i_nre, i_nwe};

    // Two-stage synchronizer and one-cycle history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
            r_prev <= '1;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            r_prev <= {r_sync[4], r_sync[1], r_sync[0]};
        end
    end

    assign o_cle      = r_sync[2];
    assign o_ale      = r_sync[3];
    assign o_nce      = r_sync[4];
    assign o_nwp      = r_sync[5];
    assign o_data     = r_sync[13:6];
    assign o_nwe_rise = r_sync[0] & ~r_prev[0];
    assign o_nre_rise = r_sync[1] & ~r_prev[1];
    assign o_nce_rise = r_sync[4] & ~r_prev[2];

endmodule
`default_nettype wire

// File: rtl/nand_target_emu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nand_target_emu                                            |
// | Purpose  : Single-page NAND flash target emulator: READ ID, STATUS,   |
// |            page READ / PROGRAM / ERASE and RESET, with R/nB timing.   |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module nand_target_emu
    import nand_target_pkg::*;
#(
    parameter int          PAGE_BYTES = 32,
    parameter int          T_BUSY     = 16,
    parameter int          T_RST      = 8,
    parameter logic [39:0] ID_BYTES   = 40'h86_03_FF_E5_2C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nand_cle,
    input  logic       nand_ale,
    input  logic       nand_nwe,
    input  logic       nand_nre,
    input  logic       nand_nce,
    input  logic       nand_nwp,
    output logic       nand_rnb,
    inout  wire [15:0] nand_data
);

    localparam int c_COL_W    = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int c_BUSY_MAX = (T_BUSY > T_RST) ? T_BUSY : T_RST;
    localparam int c_CNT_W    = $clog2(c_BUSY_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_BUSY_LOAD = c_CNT_W'(T_BUSY - 1);
    localparam logic [c_CNT_W-1:0] c_RST_LOAD  = c_CNT_W'(T_RST - 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE   = c_COL_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    logic              w_cle, w_ale, w_nce, w_nwp;
    logic [7:0]        w_data;
    logic              w_nwe_rise, w_nre_rise, w_nce_rise;

    nand_pin_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_nwe      (nand_nwe),
        .i_nre      (nand_nre),
        .i_cle      (nand_cle),
        .i_ale      (nand_ale),
        .i_nce      (nand_nce),
        .i_nwp      (nand_nwp),
        .i_data     (nand_data[7:0]),
        .o_cle      (w_cle),
        .o_ale      (w_ale),
        .o_nce      (w_nce),
        .o_nwp      (w_nwp),
        .o_data     (w_data),
        .o_nwe_rise (w_nwe_rise),
        .o_nre_rise (w_nre_rise),
        .o_nce_rise (w_nce_rise)
    );

    nand_state_e         r_state, w_state_nx;
    nand_state_e         r_prior, w_prior_nx;
    nand_state_e         w_post;
    busy_op_e            r_busy_op, w_busy_op_nx;
    logic [7:0]          r_cmd, w_cmd_nx;
    logic [2:0]          r_addr_cnt, w_addr_cnt_nx;
    logic [2:0]          r_id_idx, w_id_idx_nx;
    logic [c_COL_W-1:0]  r_col, w_col_nx;
    logic [c_CNT_W-1:0]  r_busy_cnt, w_busy_cnt_nx;
    logic                r_busy, w_busy_nx;
    logic                r_wp_ok, w_wp_ok_nx;
    logic                r_fail, w_fail_nx;
    logic [PAGE_BYTES-1:0] r_mask, w_mask_nx;
    logic [7:0]          r_dout;
    logic [7:0]          r_page [PAGE_BYTES];
    logic [7:0]          r_buf  [PAGE_BYTES];

    logic w_wr_ev, w_cmd_ev, w_addr_ev, w_data_ev, w_buf_wr;
    logic w_done, w_commit_prog, w_commit_erase, w_drive;
    logic [7:0] w_status;

    assign w_wr_ev   = w_nwe_rise & ~w_nce;
    assign w_cmd_ev  = w_wr_ev & w_cle & ~w_ale;
    assign w_addr_ev = w_wr_ev & w_ale & ~w_cle;
    assign w_data_ev = w_wr_ev & ~w_cle & ~w_ale;
    assign w_buf_wr  = w_data_ev & (r_state == ST_PROG_DATA);

    assign w_done         = r_busy & (r_busy_cnt == '0);
    assign w_commit_prog  = w_done & (r_busy_op == OP_PROG)  & r_wp_ok;
    assign w_commit_erase = w_done & (r_busy_op == OP_ERASE) & r_wp_ok;
    assign w_status       = {w_nwp, ~r_busy, ~r_busy, 4'b0000, r_fail};

    // Next-state: busy timer, read advance, address/data/command decode.
    always_comb begin
        w_state_nx    = r_state;
        w_prior_nx    = r_prior;
        w_cmd_nx      = r_cmd;
        w_addr_cnt_nx = r_addr_cnt;
        w_id_idx_nx   = r_id_idx;
        w_col_nx      = r_col;
        w_busy_nx     = r_busy;
        w_busy_cnt_nx = r_busy_cnt;
        w_busy_op_nx  = r_busy_op;
        w_wp_ok_nx    = r_wp_ok;
        w_fail_nx     = r_fail;
        w_mask_nx     = r_mask;
        w_post        = (r_busy_op == OP_READ) ? ST_OUT_PAGE : ST_IDLE;

        // The timer runs on its own so a status read can overlap it.
        if (r_busy) begin
            if (w_done) begin
                w_busy_nx = 1'b0;
                case (r_busy_op)
                    OP_READ:           w_fail_nx = 1'b0;
                    OP_PROG, OP_ERASE: w_fail_nx = ~r_wp_ok;
                    default:           ;
                endcase
                if (r_state == ST_BUSY)
                    w_state_nx = w_post;
                else if (r_state == ST_OUT_STATUS && r_prior == ST_BUSY)
                    w_prior_nx = w_post;
            end else begin
                w_busy_cnt_nx = r_busy_cnt - c_CNT_ONE;
            end
        end

        if (w_nre_rise) begin
            case (r_state)
                ST_OUT_ID:     w_id_idx_nx = (r_id_idx == 3'd4) ? 3'd0 : r_id_idx + 3'd1;
                ST_OUT_PAGE:   w_col_nx    = r_col + c_COL_ONE;
                ST_OUT_STATUS: w_state_nx  = w_prior_nx;
                default:       ;
            endcase
        end

        if (w_addr_ev && r_state == ST_ADDR && r_addr_cnt < addr_cycles(r_cmd)) begin
            if (r_addr_cnt == 3'd0)
                w_col_nx = w_data[c_COL_W-1:0];
            w_addr_cnt_nx = r_addr_cnt + 3'd1;
            if (w_addr_cnt_nx == addr_cycles(r_cmd)) begin
                if (r_cmd == c_CMD_READ_ID) begin
                    w_state_nx  = ST_OUT_ID;
                    w_id_idx_nx = 3'd0;
                end else if (r_cmd == c_CMD_PROG) begin
                    w_state_nx = ST_PROG_DATA;
                end
            end
        end

        if (w_buf_wr) begin
            w_mask_nx[r_col] = 1'b1;
            w_col_nx         = r_col + c_COL_ONE;
        end

        if (w_cmd_ev) begin
            if (w_data == c_CMD_RESET) begin
                w_state_nx    = ST_BUSY;
                w_prior_nx    = ST_IDLE;
                w_busy_nx     = 1'b1;
                w_busy_cnt_nx = c_RST_LOAD;
                w_busy_op_nx  = OP_RESET;
                w_addr_cnt_nx = 3'd0;
                w_id_idx_nx   = 3'd0;
                w_col_nx      = '0;
            end else if (w_data == c_CMD_STATUS) begin
                if (r_state != ST_OUT_STATUS) begin
                    w_prior_nx = w_state_nx;
                    w_state_nx = ST_OUT_STATUS;
                end
            end else if (!r_busy) begin
                case (w_data)
                    c_CMD_READ, c_CMD_ERASE, c_CMD_READ_ID, c_CMD_PROG: begin
                        w_state_nx    = ST_ADDR;
                        w_cmd_nx      = w_data;
                        w_addr_cnt_nx = 3'd0;
                        w_col_nx      = '0;
                        if (w_data == c_CMD_PROG)
                            w_mask_nx = '0;
                    end
                    c_CMD_READ_CONF: begin
                        if (r_state == ST_ADDR && r_cmd == c_CMD_READ && r_addr_cnt == 3'd5) begin
                            w_state_nx    = ST_BUSY;
                            w_busy_nx     = 1'b1;
                            w_busy_cnt_nx = c_BUSY_LOAD;
                            w_busy_op_nx  = OP_READ;
                        end
                    end
                    c_CMD_PROG_CONF: begin
                        if (r_state == ST_PROG_DATA) begin
                            w_state_nx    = ST_BUSY;
                            w_busy_nx     = 1'b1;
                            w_busy_cnt_nx = c_BUSY_LOAD;
                            w_busy_op_nx  = OP_PROG;
                            w_wp_ok_nx    = w_nwp;
                        end
                    end
                    c_CMD_ERASE_CNF: begin
                        if (r_state == ST_ADDR && r_cmd == c_CMD_ERASE && r_addr_cnt == 3'd3) begin
                            w_state_nx    = ST_BUSY;
                            w_busy_nx     = 1'b1;
                            w_busy_cnt_nx = c_BUSY_LOAD;
                            w_busy_op_nx  = OP_ERASE;
                            w_wp_ok_nx    = w_nwp;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Deselect drops the command interface back to idle; an array
        // operation already under way still runs to completion.
        if (w_nce_rise) begin
            w_state_nx    = ST_IDLE;
            w_prior_nx    = ST_IDLE;
            w_addr_cnt_nx = 3'd0;
            w_id_idx_nx   = 3'd0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_prior    <= ST_IDLE;
            r_cmd      <= 8'h00;
            r_addr_cnt <= 3'd0;
            r_id_idx   <= 3'd0;
            r_col      <= '0;
            r_busy     <= 1'b0;
            r_busy_cnt <= '0;
            r_busy_op  <= OP_READ;
            r_wp_ok    <= 1'b0;
            r_fail     <= 1'b0;
            r_mask     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_prior    <= w_prior_nx;
            r_cmd      <= w_cmd_nx;
            r_addr_cnt <= w_addr_cnt_nx;
            r_id_idx   <= w_id_idx_nx;
            r_col      <= w_col_nx;
            r_busy     <= w_busy_nx;
            r_busy_cnt <= w_busy_cnt_nx;
            r_busy_op  <= w_busy_op_nx;
            r_wp_ok    <= w_wp_ok_nx;
            r_fail     <= w_fail_nx;
            r_mask     <= w_mask_nx;
        end
    end

    // Page array and program buffer; contents carry no reset value.
    always_ff @(posedge clk) begin
        if (w_buf_wr)
            r_buf[r_col] <= w_data;
        for (int i = 0; i < PAGE_BYTES; i++) begin
            if (w_commit_erase)
                r_page[i] <= 8'hFF;
            else if (w_commit_prog && r_mask[i])
                r_page[i] <= r_buf[i];
        end
    end

    // Registered output byte for whichever output mode is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= 8'h00;
        end else begin
            case (r_state)
                ST_OUT_ID: begin
                    case (r_id_idx)
                        3'd1:    r_dout <= ID_BYTES[15:8];
                        3'd2:    r_dout <= ID_BYTES[23:16];
                        3'd3:    r_dout <= ID_BYTES[31:24];
                        3'd4:    r_dout <= ID_BYTES[39:32];
                        default: r_dout <= ID_BYTES[7:0];
                    endcase
                end
                ST_OUT_STATUS: r_dout <= w_status;
                ST_OUT_PAGE:   r_dout <= r_page[r_col];
                default:       r_dout <= 8'h00;
            endcase
        end
    end

    // Bus is driven only from raw strobes so release is immediate.
    assign w_drive = ~nand_nce & ~nand_nre &
                     ((r_state == ST_OUT_ID) || (r_state == ST_OUT_STATUS) ||
                      (r_state == ST_OUT_PAGE));
    assign nand_data = w_drive ? {8'h00, r_dout} : 16'hzzzz;
    assign nand_rnb  = ~r_busy;

endmodule
`default_nettype wire
